estagio_decodificacao: RTL
==========================

ESTAGIO_DECODIFICACAO -- requirements
Module: estagio_decodificacao

Interface
REQ-001 Parameter LARGURA, default 32: data and address width in bits.
REQ-002 Parameter NUM_REGISTRADORES, default 32: register file depth; index width is 5 bits.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instrucao_entrada  input  32  instruction word from memoria_instrucoes.
REQ-006 endereco_entrada  input  32  PC value from pc_counter for that instruction.
REQ-007 valido_entrada  input  1  instrucao_entrada/endereco_entrada are meaningful this cycle.
REQ-008 stall  input  1  hold the current latched instruction.
REQ-009 flush  input  1  discard the instruction being latched (bubble).
REQ-010 escrita_habilitada  input  1  write-back enable.
REQ-011 registrador_escrita  input  5  write-back register index.
REQ-012 dado_escrita  input  32  write-back data.
REQ-013 valido_saida  output  1  decoded outputs are meaningful.
REQ-014 endereco_saida  output  32  latched PC.
REQ-015 opcode  output  6; rs, rt, rd  output  5 each; shamt  output  5; funct  output  6: instruction fields.
REQ-016 imediato_estendido  output  32  sign-extended bits 15:0.
REQ-017 dado_rs, dado_rt  output  32 each  register file contents at rs/rt.

Function
REQ-018 The IF/ID latch SHALL capture instrucao_entrada, endereco_entrada and valido_entrada at posedge when stall=0 and flush=0; latency 1 cycle.
REQ-019 When stall=1 and flush=0, the latch SHALL hold its value; outputs stay unchanged except dado_rs/dado_rt, which track register file writes.
REQ-020 When flush=1, the latch SHALL load instruction 0 and valido_saida=0 at the next posedge, regardless of stall (flush beats stall).
REQ-021 Fields SHALL decode combinationally from the latched word: opcode=31:26, rs=25:21, rt=20:16, rd=15:11, shamt=10:6, funct=5:0.
REQ-022 imediato_estendido SHALL replicate bit 15 into bits 31:16.
REQ-023 The register file SHALL write dado_escrita to registrador_escrita at posedge when escrita_habilitada=1 and registrador_escrita!=0; writes occur independently of stall/flush/valid.
REQ-024 Register 0 SHALL always read 0; writes to it are discarded.
REQ-025 Reads SHALL be combinational; if escrita_habilitada=1 and registrador_escrita equals a nonzero read index in the same cycle, that read SHALL return dado_escrita (write-through bypass).
REQ-026 Outputs SHALL be driven from latched state even when valido_saida=0; consumers qualify with valido_saida.

Reset
REQ-027 At posedge with reset=1: latch cleared, valido_saida=0, endereco_saida=0, all fields and imediato_estendido=0, all registers=0.
REQ-028 reset SHALL take priority over flush, stall and write-back; a write presented during reset SHALL be dropped.
REQ-029 Reset mid-stall SHALL discard the held instruction; first capture occurs on the first posedge with reset=0 and stall=0.

Structure
REQ-030 A shared package SHALL hold opcode constants (R-type 0, J 2, JAL 3, BEQ 4, LW 35, SW 43), field bit positions and register index width.
REQ-031 The register file SHALL be a separate sub-module banco_registradores (2 read ports, 1 write port, bypass included).
REQ-032 No branch or hazard logic SHALL reside in this block; stall/flush come from outside.

Verification
REQ-033 Reset 2 cycles -> all outputs 0, valido_saida=0; dado_rs=dado_rt=0 for every index.
REQ-034 instrucao_entrada=32'h08801000, endereco_entrada=0, valido_entrada=1 -> next cycle opcode=2, rs=4, rt=0, rd=2, shamt=0, funct=0, imediato_estendido=32'h00001000, valido_saida=1.
REQ-035 Write 32'hDEADBEEF to reg 4, then latch instruction with rs=4 -> dado_rs=32'hDEADBEEF; same-cycle write 32'h12345678 to reg 4 -> dado_rs=32'h12345678 immediately.
REQ-036 Write 32'hFFFFFFFF to reg 0 -> dado_rs=0 when rs=0; instruction with bits 15:0=16'h8000 -> imediato_estendido=32'hFFFF8000.
REQ-037 Latch PC 4, assert stall 3 cycles with new inputs at PC 5..7 -> endereco_saida stays 4; stall+flush together -> valido_saida=0 next cycle.
REQ-038 Assert reset during stall with write-back to reg 7 -> reg 7 reads 0 afterwards, valido_saida=0.

Source files
------------

// File: rtl/estagio_decodificacao_pkg.sv
// Shared definitions for the decode stage: instruction field positions,
// register index width and the opcodes the rest of the pipeline recognises.
package estagio_decodificacao_pkg;

  localparam int LARGURA_INSTRUCAO = 32;
  localparam int LARGURA_INDICE    = 5;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMED_MSB   = 15;

  typedef enum logic [5:0] {
    OP_TIPO_R = 6'd0,
    OP_J      = 6'd2,
    OP_JAL    = 6'd3,
    OP_BEQ    = 6'd4,
    OP_LW     = 6'd35,
    OP_SW     = 6'd43
  } opcode_e;

  function automatic logic [31:0] estender_sinal(input logic [15:0] imed);
    return {{16{imed[15]}}, imed};
  endfunction

endpackage

// File: rtl/estagio_decodificacao_banco_registradores.sv
// Register file with two combinational read ports, one write port and a
// write-through bypass so a same-cycle write is visible on the reads.
import estagio_decodificacao_pkg::*;

module banco_registradores #(
  parameter int LARGURA           = 32,
  parameter int NUM_REGISTRADORES = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [LARGURA_INDICE-1:0] i_endereco_a,
  input  logic [LARGURA_INDICE-1:0] i_endereco_b,
  input  logic                      i_escrita_habilitada,
  input  logic [LARGURA_INDICE-1:0] i_endereco_escrita,
  input  logic [LARGURA-1:0]        i_dado_escrita,
  output logic [LARGURA-1:0]        o_dado_a,
  output logic [LARGURA-1:0]        o_dado_b
);

  logic [LARGURA-1:0] r_registradores [NUM_REGISTRADORES];
  logic               w_escreve;

  assign w_escreve = i_escrita_habilitada && (i_endereco_escrita != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGISTRADORES; i++) begin
        r_registradores[i] <= '0;
      end
    end else if (w_escreve) begin
      r_registradores[i_endereco_escrita] <= i_dado_escrita;
    end
  end

  // Register 0 is hardwired; otherwise a pending write wins over stored data.
  always_comb begin
    o_dado_a = '0;
    o_dado_b = '0;
    if (i_endereco_a != '0) begin
      o_dado_a = (w_escreve && i_endereco_escrita == i_endereco_a) ?
                 i_dado_escrita : r_registradores[i_endereco_a];
    end
    if (i_endereco_b != '0) begin
      o_dado_b = (w_escreve && i_endereco_escrita == i_endereco_b) ?
                 i_dado_escrita : r_registradores[i_endereco_b];
    end
  end

endmodule

// File: rtl/estagio_decodificacao.sv
// Instruction decode stage: IF/ID latch with stall/flush, field decode,
// immediate sign extension and register file operand read.
import estagio_decodificacao_pkg::*;

module estagio_decodificacao #(
  parameter int LARGURA           = 32,
  parameter int NUM_REGISTRADORES = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [LARGURA_INSTRUCAO-1:0] instrucao_entrada,
  input  logic [LARGURA-1:0]           endereco_entrada,
  input  logic                         valido_entrada,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         escrita_habilitada,
  input  logic [LARGURA_INDICE-1:0]    registrador_escrita,
  input  logic [LARGURA-1:0]           dado_escrita,
  output logic                         valido_saida,
  output logic [LARGURA-1:0]           endereco_saida,
  output logic [5:0]                   opcode,
  output logic [LARGURA_INDICE-1:0]    rs,
  output logic [LARGURA_INDICE-1:0]    rt,
  output logic [LARGURA_INDICE-1:0]    rd,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [LARGURA-1:0]           imediato_estendido,
  output logic [LARGURA-1:0]           dado_rs,
  output logic [LARGURA-1:0]           dado_rt
);

  logic [LARGURA_INSTRUCAO-1:0] r_instrucao;
  logic [LARGURA-1:0]           r_endereco;
  logic                         r_valido;
  logic [31:0]                  w_imediato;

  // Flush outranks stall so a squashed slot always becomes a bubble.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_instrucao <= '0;
      r_endereco  <= '0;
      r_valido    <= 1'b0;
    end else if (!stall) begin
      r_instrucao <= instrucao_entrada;
      r_endereco  <= endereco_entrada;
      r_valido    <= valido_entrada;
    end
  end

  assign valido_saida   = r_valido;
  assign endereco_saida = r_endereco;
  assign opcode         = r_instrucao[OPCODE_MSB:OPCODE_LSB];
  assign rs             = r_instrucao[RS_MSB:RS_LSB];
  assign rt             = r_instrucao[RT_MSB:RT_LSB];
  assign rd             = r_instrucao[RD_MSB:RD_LSB];
  assign shamt          = r_instrucao[SHAMT_MSB:SHAMT_LSB];
  assign funct          = r_instrucao[FUNCT_MSB:FUNCT_LSB];
  assign w_imediato     = estender_sinal(r_instrucao[IMED_MSB:0]);
  assign imediato_estendido = LARGURA'(w_imediato);

  banco_registradores #(
    .LARGURA           (LARGURA),
    .NUM_REGISTRADORES (NUM_REGISTRADORES)
  ) u_banco_registradores (
    .clock                (clock),
    .reset                (reset),
    .i_endereco_a         (rs),
    .i_endereco_b         (rt),
    .i_escrita_habilitada (escrita_habilitada),
    .i_endereco_escrita   (registrador_escrita),
    .i_dado_escrita       (dado_escrita),
    .o_dado_a             (dado_rs),
    .o_dado_b             (dado_rt)
  );

endmodule
